// File: rtl/load_extend.sv
// Load byte/half/word/dword extraction with sign/zero extension into a 2-entry in-order result buffer.
// Result visible one cycle after accept; in_ready depends only on buffer occupancy, never on out_ready.
module load_extend #(
  parameter int DATA_BITS    = 32,
  parameter int SIGN_DEFAULT = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_BITS-1:0]               in_data,
  input  logic [$clog2(DATA_BITS/8)-1:0]     in_offset,
  input  logic [1:0]                         in_size,
  input  logic                               in_signed,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_BITS-1:0]               out_data,
  output logic                               out_misaligned
);

  localparam int OFF_BITS = $clog2(DATA_BITS/8);
  localparam logic [1:0] SIZE_MAX = (DATA_BITS == 64) ? 2'd3 : 2'd2;

  // SIGN_DEFAULT only documents the integrator's tie-off value for in_signed.
  logic unused_sign_default;
  assign unused_sign_default = SIGN_DEFAULT[0];

  logic [1:0]           cnt;
  logic [DATA_BITS-1:0] d0, d1;
  logic                 m0, m1;
  logic                 accept, pop;

  logic [DATA_BITS-1:0] sh, himask, new_data;
  logic [6:0]           w;
  logic                 sb, new_mis;
  logic [OFF_BITS-1:0]  amask;

  assign in_ready       = (cnt != 2'd2);
  assign out_valid      = (cnt != 2'd0);
  assign out_data       = d0;
  assign out_misaligned = m0;
  assign accept         = in_valid & in_ready;
  assign pop            = out_valid & out_ready;

  always_comb begin
    sh     = in_data >> {in_offset, 3'b000};
    w      = 7'd8 << in_size;
    // A shift by the full word width yields zero, so full-width fields get no fill bits.
    himask = {DATA_BITS{1'b1}} << w;
    case (in_size)
      2'd0:    sb = sh[7];
      2'd1:    sb = sh[15];
      2'd2:    sb = sh[31];
      default: sb = sh[DATA_BITS-1];
    endcase
    amask    = OFF_BITS'((4'd1 << in_size) - 4'd1);
    new_mis  = (in_size > SIZE_MAX) | (|(in_offset & amask));
    new_data = new_mis ? '0 : ((sh & ~himask) | ((in_signed & sb) ? himask : '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
      d0  <= '0;
      d1  <= '0;
      m0  <= 1'b0;
      m1  <= 1'b0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      if (pop) begin
        d0 <= d1;
        m0 <= m1;
      end
      // New entry lands at the head only if the buffer is (or becomes) empty this cycle.
      if (accept) begin
        if (cnt == 2'd0 || (cnt == 2'd1 && pop)) begin
          d0 <= new_data;
          m0 <= new_mis;
        end else begin
          d1 <= new_data;
          m1 <= new_mis;
        end
      end
      cnt <= cnt + {1'b0, accept} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_load_extend.sv
// Bench for load_extend: directed vector table, backpressure/flush/reset sequences, randomized scoreboard run.
module tb_load_extend;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_signed, out_valid, out_ready, out_misaligned;
  logic [31:0] in_data, out_data;
  logic [1:0]  in_offset, in_size;

  logic        rst64, flush64, iv64, ir64, sg64, ov64, or64, om64;
  logic [63:0] id64, od64;
  logic [2:0]  io64;
  logic [1:0]  is64;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  load_extend #(.DATA_BITS(32), .SIGN_DEFAULT(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_offset(in_offset), .in_size(in_size), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_misaligned(out_misaligned)
  );

  load_extend #(.DATA_BITS(64), .SIGN_DEFAULT(0)) dut64 (
    .clk(clk), .rst(rst64), .flush(flush64), .in_valid(iv64), .in_ready(ir64),
    .in_data(id64), .in_offset(io64), .in_size(is64), .in_signed(sg64),
    .out_valid(ov64), .out_ready(or64), .out_data(od64), .out_misaligned(om64)
  );

  typedef struct {
    logic [31:0] data;
    int          off;
    int          size;
    bit          sgn;
    logic [31:0] exp_data;
    bit          exp_mis;
  } vec_t;

  vec_t vt[8];
  logic [32:0] q[$];
  logic [32:0] bp_exp[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: field of 8<<size bits at byte offset, extended by integer arithmetic; returns {mis, data}.
  function automatic logic [64:0] ref_ld(input int db, input logic [63:0] data, input int off,
                                         input int size, input bit sgn);
    int nb, w;
    logic [63:0] field;
    nb = 1 << size;
    w  = 8 * nb;
    if (w > db || (off % nb) != 0) return {1'b1, 64'd0};
    field = data >> (8 * off);
    if (w < 64) begin
      field = field % (64'd1 << w);
      if (sgn && field >= (64'd1 << (w - 1))) field = field - (64'd1 << w);
    end
    if (db == 32) field = field % (64'd1 << 32);
    return {1'b0, field};
  endfunction

  function automatic logic [32:0] ref32(input logic [31:0] d, input int off, input int size, input bit sgn);
    logic [64:0] r;
    r = ref_ld(32, {32'd0, d}, off, size, sgn);
    return {r[64], r[31:0]};
  endfunction

  task automatic drive(input logic [31:0] d, input int off, input int size, input bit sgn);
    in_valid  = 1'b1;
    in_data   = d;
    in_offset = 2'(off);
    in_size   = 2'(size);
    in_signed = sgn;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [32:0] e;
    int got;
    bit acc;

    vt[0] = '{32'h8812_34F0, 1, 0, 1'b1, 32'h0000_0034, 1'b0};
    vt[1] = '{32'h8812_34F0, 3, 0, 1'b1, 32'hFFFF_FF88, 1'b0};
    vt[2] = '{32'h8001_0000, 2, 1, 1'b0, 32'h0000_8001, 1'b0};
    vt[3] = '{32'h8001_0000, 2, 1, 1'b1, 32'hFFFF_8001, 1'b0};
    vt[4] = '{32'h8001_0000, 1, 1, 1'b1, 32'h0000_0000, 1'b1};
    vt[5] = '{32'h1234_5678, 0, 3, 1'b0, 32'h0000_0000, 1'b1};
    vt[6] = '{32'h1234_5678, 2, 3, 1'b1, 32'h0000_0000, 1'b1};
    vt[7] = '{32'hDEAD_BEEF, 0, 2, 1'b1, 32'hDEAD_BEEF, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_offset = '0; in_size = '0; in_signed = 1'b0;
    rst64 = 1'b1; flush64 = 1'b0; iv64 = 1'b0; or64 = 1'b0;
    id64 = '0; io64 = '0; is64 = '0; sg64 = 1'b0;
    tick; tick;
    rst = 1'b0; rst64 = 1'b0;

    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_out_mis", {63'd0, out_misaligned}, 64'd0);

    // Directed table: one-cycle latency, popped the cycle after.
    out_ready = 1'b1;
    foreach (vt[i]) begin
      drive(vt[i].data, vt[i].off, vt[i].size, vt[i].sgn);
      tick;
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("vec%0d_data", i), {32'd0, out_data}, {32'd0, vt[i].exp_data});
      chk($sformatf("vec%0d_mis", i), {63'd0, out_misaligned}, {63'd0, vt[i].exp_mis});
      tick;
      chk($sformatf("vec%0d_drain", i), {63'd0, out_valid}, 64'd0);
    end

    // Backpressure: third request held while full, then all three drain in order.
    out_ready = 1'b0;
    bp_exp[0] = ref32(32'h0000_A5C3, 0, 0, 1'b1);
    bp_exp[1] = ref32(32'h7F00_1234, 2, 1, 1'b0);
    bp_exp[2] = ref32(32'h00C8_0000, 2, 0, 1'b1);
    drive(32'h0000_A5C3, 0, 0, 1'b1);
    chk("bp_ready0", {63'd0, in_ready}, 64'd1);
    tick;
    drive(32'h7F00_1234, 2, 1, 1'b0);
    tick;
    drive(32'h00C8_0000, 2, 0, 1'b1);
    chk("bp_full_ready", {63'd0, in_ready}, 64'd0);
    tick;
    chk("bp_held_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_stable_data", {31'd0, out_misaligned, out_data}, {31'd0, bp_exp[0]});
    out_ready = 1'b1;
    chk("bp_no_accept_at_full", {63'd0, in_ready}, 64'd0);
    got = 0;
    for (int i = 0; i < 12 && got < 3; i++) begin
      if (out_valid) begin
        chk($sformatf("bp_order%0d", got), {31'd0, out_misaligned, out_data}, {31'd0, bp_exp[got]});
        got++;
      end
      acc = in_valid && in_ready;
      tick;
      if (acc) in_valid = 1'b0;
    end
    chk("bp_count", 64'(got), 64'd3);
    chk("bp_no_dup", {63'd0, out_valid}, 64'd0);

    // Flush at full with a request offered: everything dropped.
    out_ready = 1'b0;
    drive(32'h1111_1111, 0, 2, 1'b0); tick;
    drive(32'h2222_2222, 0, 2, 1'b0); tick;
    drive(32'h3333_3333, 0, 2, 1'b0);
    flush = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_valid", {63'd0, out_valid}, 64'd0);
    chk("flush2_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    tick;
    chk("flush2_nothing_left", {63'd0, out_valid}, 64'd0);

    // Flush with one entry: in_ready stays high but the request is discarded.
    out_ready = 1'b0;
    drive(32'h4444_4444, 0, 2, 1'b0); tick;
    drive(32'h5555_5555, 0, 2, 1'b0);
    flush = 1'b1;
    chk("flush1_ready", {63'd0, in_ready}, 64'd1);
    tick;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_valid", {63'd0, out_valid}, 64'd0);

    // Reset mid-operation.
    drive(32'h6666_6666, 0, 2, 1'b0); tick;
    in_valid = 1'b0;
    rst = 1'b1; tick; rst = 1'b0;
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_data", {32'd0, out_data}, 64'd0);

    // Randomized run against the queue model.
    q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_data   = $urandom;
      in_offset = 2'($urandom_range(0, 3));
      in_size   = 2'($urandom_range(0, 3));
      in_signed = 1'($urandom_range(0, 1));
      chk("rnd_in_ready", {63'd0, in_ready}, {63'd0, q.size() != 2});
      chk("rnd_out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
      if (q.size() != 0)
        chk("rnd_head", {31'd0, out_misaligned, out_data}, {31'd0, q[0]});
      if (flush) q.delete();
      else begin
        e = ref32(in_data, int'(in_offset), int'(in_size), in_signed);
        acc = in_valid && (q.size() != 2);
        if (out_ready && q.size() != 0) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      tick;
    end
    in_valid = 1'b0; flush = 1'b0;

    // 64-bit instance: word sign-extension, dword pass-through, misaligned dword, reset at cnt=1.
    or64 = 1'b0;
    iv64 = 1'b1; id64 = 64'hF000_0000_0000_0000; io64 = 3'd4; is64 = 2'd2; sg64 = 1'b1;
    tick;
    iv64 = 1'b0;
    chk("w64_valid", {63'd0, ov64}, 64'd1);
    chk("w64_data", od64, 64'hFFFF_FFFF_F000_0000);
    chk("w64_mis", {63'd0, om64}, 64'd0);
    rst64 = 1'b1; tick; rst64 = 1'b0;
    chk("w64_rst_valid", {63'd0, ov64}, 64'd0);
    chk("w64_rst_data", od64, 64'd0);
    chk("w64_rst_ready", {63'd0, ir64}, 64'd1);
    or64 = 1'b1;
    iv64 = 1'b1; id64 = 64'h8123_4567_89AB_CDEF; io64 = 3'd0; is64 = 2'd3; sg64 = 1'b0;
    tick;
    iv64 = 1'b0;
    chk("w64_dword", od64, ref_ld(64, 64'h8123_4567_89AB_CDEF, 0, 3, 1'b0) & 65'h0_FFFF_FFFF_FFFF_FFFF);
    iv64 = 1'b1; io64 = 3'd4; is64 = 2'd3;
    tick;
    iv64 = 1'b0;
    chk("w64_dword_mis", {63'd0, om64}, 64'd1);
    chk("w64_dword_mis_data", od64, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
